// File: rtl/md_issue_ctrl.sv
// Execute-stage sequencer for the RV32M multiply/divide unit: decodes MUL..REMU,
// issues operands plus a one-hot op type, stalls while the unit is busy, and emits one writeback.
module md_issue_ctrl #(
    parameter int TIMEOUT = 40,
    parameter int CNT_W   = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [31:0] id_inst,
    input  logic [31:0] rs1_val,
    input  logic [31:0] rs2_val,
    input  logic        flush,
    output logic        stall,
    output logic [31:0] md_x,
    output logic [31:0] md_y,
    output logic [7:0]  md_type,
    input  logic [31:0] md_out,
    input  logic        md_pending,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        md_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       funct3_q;

    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic       m_hit;
    logic       accept;
    logic       timeout_hit;
    logic       unused_fields;

    assign opcode = id_inst[6:0];
    assign rd     = id_inst[11:7];
    assign funct3 = id_inst[14:12];
    assign funct7 = id_inst[31:25];

    // Register-source fields are not needed: operand values arrive already read.
    assign unused_fields = ^id_inst[24:15];

    assign m_hit       = id_valid && (opcode == OPC_OP) && (funct7 == F7_MULDIV);
    assign accept      = (state_q == IDLE) && m_hit && !flush;
    assign timeout_hit = md_pending && (cnt_q == CNT_LAST);

    // Next-state and combinational outputs
    always_comb begin
        state_d  = state_q;
        stall    = 1'b0;
        md_type  = 8'h00;
        wb_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = ISSUE;
                    stall   = 1'b1;
                end
            end
            ISSUE: begin
                stall   = 1'b1;
                md_type = 8'h01 << funct3_q;
                // The unit is still loading operands, so md_pending is not meaningful yet.
                state_d = flush ? IDLE : WAIT;
            end
            WAIT: begin
                stall   = 1'b1;
                md_type = 8'h01 << funct3_q;
                if (flush) begin
                    state_d = IDLE;
                end else if (!md_pending || timeout_hit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                wb_valid = !flush;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            funct3_q <= 3'd0;
            md_x     <= 32'd0;
            md_y     <= 32'd0;
            wb_rd    <= 5'd0;
            wb_data  <= 32'd0;
            md_err   <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        md_x     <= rs1_val;
                        md_y     <= rs2_val;
                        wb_rd    <= rd;
                        funct3_q <= funct3;
                        cnt_q    <= '0;
                    end
                end
                ISSUE: begin
                    if (flush) begin
                        cnt_q <= '0;
                    end
                end
                WAIT: begin
                    if (flush) begin
                        cnt_q <= '0;
                    end else if (!md_pending) begin
                        wb_data <= md_out;
                    end else if (timeout_hit) begin
                        // Abandon a hung unit; the counter stops here so it can never wrap.
                        wb_data <= 32'd0;
                        md_err  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed testbench for md_issue_ctrl: per-scenario tasks with hand-computed expectations.
module tb_md_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic        flush;
    logic        stall;
    logic [31:0] md_x;
    logic [31:0] md_y;
    logic [7:0]  md_type;
    logic [31:0] md_out;
    logic        md_pending;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        md_err;

    int errors = 0;
    int checks = 0;

    md_issue_ctrl #(.TIMEOUT(40), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_inst(id_inst),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .flush(flush), .stall(stall),
        .md_x(md_x), .md_y(md_y), .md_type(md_type), .md_out(md_out),
        .md_pending(md_pending), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .wb_data(wb_data), .md_err(md_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk_inst(input logic [6:0] f7, input logic [2:0] f3,
                                            input logic [4:0] rd);
        mk_inst = {f7, 5'd2, 5'd1, f3, rd, 7'b0110011};
    endfunction

    task automatic idle_inputs();
        id_valid = 1'b0; id_inst = 32'd0; rs1_val = 32'd0; rs2_val = 32'd0;
        flush = 1'b0; md_out = 32'd0; md_pending = 1'b0;
    endtask

    // Drives one M op (accepted at k=0) and records what the DUT did over ncyc cycles.
    task automatic run_op(input logic [31:0] inst, input logic [31:0] x, input logic [31:0] y,
                          input int npend, input logic [31:0] result, input int flush_k,
                          input int ncyc, input logic [7:0] exp_type,
                          output int stall_n, output int wb_n, output int wb_k,
                          output logic [31:0] wbd, output logic [4:0] wbr,
                          output logic [31:0] xs, output logic [31:0] ys,
                          output logic [7:0] type1, output int type_nz, output int type_bad);
        stall_n = 0; wb_n = 0; wb_k = -1; wbd = 32'hx; wbr = 5'hx;
        xs = 32'hx; ys = 32'hx; type1 = 8'hx; type_nz = 0; type_bad = 0;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            id_valid   = (k == 0);
            id_inst    = inst;
            rs1_val    = x;
            rs2_val    = y;
            md_pending = (k >= 2) && ((k - 2) < npend);
            md_out     = result;
            flush      = (k == flush_k);
            #1;
            if (stall) stall_n++;
            if (wb_valid) begin
                wb_n++; wb_k = k; wbd = wb_data; wbr = wb_rd;
            end
            if (k == 1) begin
                xs = md_x; ys = md_y; type1 = md_type;
            end
            if (md_type != 8'h00) begin
                type_nz++;
                if (md_type !== exp_type) type_bad++;
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    int sn, wn, wk, tnz, tbad;
    logic [31:0] wd, xs, ys;
    logic [4:0]  wr;
    logic [7:0]  t1;

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        #12;
        checks++; if ({stall, wb_valid, md_err} !== 3'b000) begin errors++;
            $display("FAIL reset_ctrl: stall/wb_valid/md_err=%b expected 000", {stall, wb_valid, md_err}); end
        checks++; if ({md_x, md_y, md_type, wb_rd, wb_data} !== 109'd0) begin errors++;
            $display("FAIL reset_data: x=%h y=%h type=%h rd=%h data=%h expected all 0",
                     md_x, md_y, md_type, wb_rd, wb_data); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_mul();
        run_op(mk_inst(7'h01, 3'd0, 5'd5), 32'd7, 32'd6, 2, 32'd42, -1, 8, 8'h01,
               sn, wn, wk, wd, wr, xs, ys, t1, tnz, tbad);
        checks++; if ({xs, ys} !== {32'd7, 32'd6}) begin errors++;
            $display("FAIL mul_operands: x=%0d y=%0d expected 7 6", xs, ys); end
        checks++; if (t1 !== 8'h01 || tbad != 0 || tnz != 4) begin errors++;
            $display("FAIL mul_type: type=%h bad=%0d nz=%0d expected 01 0 4", t1, tbad, tnz); end
        checks++; if (sn != 5) begin errors++;
            $display("FAIL mul_stall_cycles: got %0d expected 5", sn); end
        checks++; if (wn != 1 || wk != 5) begin errors++;
            $display("FAIL mul_wb_pulse: count=%0d at=%0d expected 1 at 5", wn, wk); end
        checks++; if (wd !== 32'd42 || wr !== 5'd5) begin errors++;
            $display("FAIL mul_wb_data: data=%0d rd=%0d expected 42 5", wd, wr); end
    endtask

    task automatic test_divu();
        run_op(mk_inst(7'h01, 3'd5, 5'd12), 32'd100, 32'd7, 0, 32'd14, -1, 6, 8'h20,
               sn, wn, wk, wd, wr, xs, ys, t1, tnz, tbad);
        checks++; if (t1 !== 8'h20 || tbad != 0 || tnz != 2) begin errors++;
            $display("FAIL divu_type: type=%h bad=%0d nz=%0d expected 20 0 2", t1, tbad, tnz); end
        checks++; if (wn != 1 || wk != 3 || sn != 3) begin errors++;
            $display("FAIL divu_latency: wb=%0d at=%0d stall=%0d expected 1 at 3 stall 3", wn, wk, sn); end
        checks++; if (wd !== 32'd14 || wr !== 5'd12) begin errors++;
            $display("FAIL divu_wb_data: data=%0d rd=%0d expected 14 12", wd, wr); end
    endtask

    task automatic test_flush();
        run_op(mk_inst(7'h01, 3'd1, 5'd9), 32'hFFFF_FFFD, 32'd5, 100, 32'd99, 3, 8, 8'h02,
               sn, wn, wk, wd, wr, xs, ys, t1, tnz, tbad);
        checks++; if (t1 !== 8'h02 || tnz != 3 || tbad != 0) begin errors++;
            $display("FAIL flush_wait_type: type=%h nz=%0d bad=%0d expected 02 3 0", t1, tnz, tbad); end
        checks++; if (wn != 0 || sn != 4) begin errors++;
            $display("FAIL flush_wait_wb: wb=%0d stall=%0d expected 0 4", wn, sn); end
        checks++; if (wb_data !== 32'd14 || wb_rd !== 5'd9) begin errors++;
            $display("FAIL flush_hold: data=%0d rd=%0d expected 14 9", wb_data, wb_rd); end
        // A following ADD must flow through without stalling.
        @(negedge clk);
        id_valid = 1'b1; id_inst = mk_inst(7'h00, 3'd0, 5'd4);
        #1;
        checks++; if (stall !== 1'b0) begin errors++;
            $display("FAIL add_unstalled: stall=%b expected 0", stall); end
        @(negedge clk);
        #1;
        checks++; if ({stall, md_type, wb_valid} !== 10'd0) begin errors++;
            $display("FAIL add_no_op: stall=%b type=%h wb=%b expected 0", stall, md_type, wb_valid); end
        // id_valid low with an M encoding present.
        id_valid = 1'b0; id_inst = mk_inst(7'h01, 3'd0, 5'd4);
        #1;
        checks++; if (stall !== 1'b0) begin errors++;
            $display("FAIL invalid_m_stall: stall=%b expected 0", stall); end
        @(negedge clk);
        #1;
        checks++; if (md_type !== 8'h00) begin errors++;
            $display("FAIL invalid_m_type: type=%h expected 00", md_type); end
        idle_inputs();

        run_op(mk_inst(7'h01, 3'd7, 5'd6), 32'd1, 32'd2, 5, 32'd3, 1, 6, 8'h80,
               sn, wn, wk, wd, wr, xs, ys, t1, tnz, tbad);
        checks++; if (wn != 0 || sn != 2 || tnz != 1) begin errors++;
            $display("FAIL flush_issue: wb=%0d stall=%0d nz=%0d expected 0 2 1", wn, sn, tnz); end

        run_op(mk_inst(7'h01, 3'd4, 5'd6), 32'd1, 32'd2, 0, 32'd3, 3, 6, 8'h10,
               sn, wn, wk, wd, wr, xs, ys, t1, tnz, tbad);
        checks++; if (wn != 0 || sn != 3) begin errors++;
            $display("FAIL flush_done: wb=%0d stall=%0d expected 0 3", wn, sn); end

        run_op(mk_inst(7'h01, 3'd0, 5'd6), 32'd1, 32'd2, 0, 32'd3, 0, 6, 8'h01,
               sn, wn, wk, wd, wr, xs, ys, t1, tnz, tbad);
        checks++; if (wn != 0 || sn != 0 || tnz != 0) begin errors++;
            $display("FAIL flush_accept: wb=%0d stall=%0d nz=%0d expected 0 0 0", wn, sn, tnz); end
    endtask

    task automatic test_rd0_divzero();
        run_op(mk_inst(7'h01, 3'd0, 5'd0), 32'd3, 32'd3, 1, 32'd9, -1, 6, 8'h01,
               sn, wn, wk, wd, wr, xs, ys, t1, tnz, tbad);
        checks++; if (wn != 1 || wk != 4 || wr !== 5'd0 || wd !== 32'd9) begin errors++;
            $display("FAIL rd0_wb: wb=%0d at=%0d rd=%0d data=%0d expected 1 4 0 9", wn, wk, wr, wd); end
        run_op(mk_inst(7'h01, 3'd5, 5'd2), 32'd55, 32'd0, 0, 32'hFFFF_FFFF, -1, 6, 8'h20,
               sn, wn, wk, wd, wr, xs, ys, t1, tnz, tbad);
        checks++; if (wn != 1 || wd !== 32'hFFFF_FFFF || ys !== 32'd0) begin errors++;
            $display("FAIL divzero_pass: wb=%0d data=%h y=%h expected 1 ffffffff 0", wn, wd, ys); end
    endtask

    task automatic test_timeout();
        checks++; if (md_err !== 1'b0) begin errors++;
            $display("FAIL err_before_timeout: md_err=%b expected 0", md_err); end
        run_op(mk_inst(7'h01, 3'd0, 5'd3), 32'd1, 32'd1, 1000, 32'h1234, -1, 46, 8'h01,
               sn, wn, wk, wd, wr, xs, ys, t1, tnz, tbad);
        checks++; if (wn != 1 || wk != 42 || sn != 42 || tnz != 41) begin errors++;
            $display("FAIL timeout_timing: wb=%0d at=%0d stall=%0d nz=%0d expected 1 42 42 41",
                     wn, wk, sn, tnz); end
        checks++; if (wd !== 32'd0 || md_err !== 1'b1) begin errors++;
            $display("FAIL timeout_result: data=%h err=%b expected 0 1", wd, md_err); end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  ty [10];
        logic        st [10];
        logic        wv [10];
        logic [31:0] wdat [10];
        logic [4:0]  wrd [10];
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            id_valid   = (k == 0) || (k == 4);
            id_inst    = (k < 4) ? mk_inst(7'h01, 3'd6, 5'd7) : mk_inst(7'h01, 3'd3, 5'd8);
            rs1_val    = (k < 4) ? 32'd23 : 32'd65536;
            rs2_val    = (k < 4) ? 32'd4 : 32'd65536;
            md_out     = (k < 4) ? 32'd11 : 32'd22;
            md_pending = 1'b0;
            flush      = 1'b0;
            #1;
            ty[k] = md_type; st[k] = stall; wv[k] = wb_valid; wdat[k] = wb_data; wrd[k] = wb_rd;
        end
        idle_inputs();
        checks++; if ({ty[1], ty[2], ty[3], ty[4], ty[5], ty[6], ty[7]} !== 56'h40_40_00_00_08_08_00) begin
            errors++;
            $display("FAIL b2b_types: %h %h %h %h %h %h %h expected 40 40 00 00 08 08 00",
                     ty[1], ty[2], ty[3], ty[4], ty[5], ty[6], ty[7]); end
        checks++; if ({st[3], st[4], st[7]} !== 3'b010) begin errors++;
            $display("FAIL b2b_stall: done=%b accept=%b done2=%b expected 0 1 0", st[3], st[4], st[7]); end
        checks++; if ({wv[2], wv[3], wv[4], wv[6], wv[7], wv[8]} !== 6'b010010) begin errors++;
            $display("FAIL b2b_wb_pulses: %b expected 010010", {wv[2], wv[3], wv[4], wv[6], wv[7], wv[8]}); end
        checks++; if (wdat[3] !== 32'd11 || wrd[3] !== 5'd7 || wdat[7] !== 32'd22 || wrd[7] !== 5'd8) begin
            errors++;
            $display("FAIL b2b_wb_data: %0d/%0d and %0d/%0d expected 11/7 and 22/8",
                     wdat[3], wrd[3], wdat[7], wrd[7]); end
        checks++; if (md_err !== 1'b1) begin errors++;
            $display("FAIL err_sticky: md_err=%b expected 1", md_err); end
    endtask

    task automatic test_async_reset();
        int wb_seen;
        int stall_seen;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            id_valid = (k == 0); id_inst = mk_inst(7'h01, 3'd2, 5'd10);
            rs1_val = 32'hAAAA_0001; rs2_val = 32'h5555_0002;
            md_pending = 1'b1; md_out = 32'h77;
        end
        #2;
        checks++; if (stall !== 1'b1 || md_type !== 8'h04) begin errors++;
            $display("FAIL pre_reset_wait: stall=%b type=%h expected 1 04", stall, md_type); end
        rst = 1'b1;
        #1;
        checks++; if ({stall, wb_valid, md_err, md_type, wb_rd} !== 16'd0 ||
                      {md_x, md_y, wb_data} !== 96'd0) begin errors++;
            $display("FAIL async_reset: stall=%b wb=%b err=%b type=%h rd=%h x=%h y=%h data=%h expected 0",
                     stall, wb_valid, md_err, md_type, wb_rd, md_x, md_y, wb_data); end
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        wb_seen = 0; stall_seen = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            if (wb_valid) wb_seen++;
            if (stall) stall_seen++;
        end
        checks++; if (wb_seen != 0 || stall_seen != 0) begin errors++;
            $display("FAIL post_reset_idle: wb=%0d stall=%0d expected 0 0", wb_seen, stall_seen); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_divu();
        test_flush();
        test_rd0_divzero();
        test_timeout();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
